dump_unit: RTL and testbench

//  Hardware replacement for the bench-side register/memory dump that runs on halt.

---
 rtl/dump_unit.sv | 202 ++++++++++++++++++++
 tb/tb_dump_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_unit.sv
// Post-halt state dump: streams the register file, then a window of data memory,
// as tagged words over a valid/ready interface. Outputs are all registered.
module dump_unit #(
    parameter int               WORD     = 32,
    parameter int               ADDR     = 32,
    parameter int               W_RD     = 4,
    parameter int               N_REG    = 16,
    parameter int               N_MEM    = 16,
    parameter logic [ADDR-1:0]  MEM_BASE = {ADDR{1'b0}},
    parameter int               W_IDX    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [W_RD-1:0]  reg_r_o,
    input  logic [WORD-1:0]  reg_data_i,
    output logic [ADDR-1:0]  mem_a_o,
    output logic             mem_w_o,
    input  logic [WORD-1:0]  mem_data_i,
    output logic             dump_v_o,
    input  logic             dump_rdy_i,
    output logic             dump_sel_o,
    output logic [W_IDX-1:0] dump_idx_o,
    output logic [WORD-1:0]  dump_data_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REG_CAP = 3'd1,
        REG_OUT = 3'd2,
        MEM_REQ = 3'd3,
        MEM_CAP = 3'd4,
        MEM_OUT = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam bit               HAS_MEM  = (N_MEM > 0);
    localparam logic [W_IDX-1:0] REG_LAST = W_IDX'(N_REG - 1);
    localparam logic [W_IDX-1:0] MEM_LAST = W_IDX'((N_MEM > 0) ? (N_MEM - 1) : 0);
    localparam logic [W_IDX-1:0] IDX_ONE  = W_IDX'(1);

    state_t           state_r, state_s;
    logic [W_IDX-1:0] idx_r, idx_s, idx_inc_s;
    logic             busy_r, busy_s, done_r, done_s;
    logic             v_r, v_s, sel_r, sel_s;
    logic [W_RD-1:0]  reg_r_r, reg_r_s;
    logic [ADDR-1:0]  mem_a_r, mem_a_s;
    logic [W_IDX-1:0] didx_r, didx_s;
    logic [WORD-1:0]  data_r, data_s;
    logic             xfer_s, reg_last_s, mem_last_s;

    assign xfer_s     = v_r & dump_rdy_i;
    assign reg_last_s = (idx_r == REG_LAST);
    assign mem_last_s = (idx_r == MEM_LAST);
    assign idx_inc_s  = idx_r + IDX_ONE;

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            idx_r   <= {W_IDX{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            v_r     <= 1'b0;
            sel_r   <= 1'b0;
            reg_r_r <= {W_RD{1'b0}};
            mem_a_r <= {ADDR{1'b0}};
            didx_r  <= {W_IDX{1'b0}};
            data_r  <= {WORD{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            v_r     <= v_s;
            sel_r   <= sel_s;
            reg_r_r <= reg_r_s;
            mem_a_r <= mem_a_s;
            didx_r  <= didx_s;
            data_r  <= data_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (halt_i) state_s = REG_CAP; else state_s = IDLE;
            REG_CAP: state_s = REG_OUT;
            REG_OUT: begin
                if (xfer_s) begin
                    if (!reg_last_s)  state_s = REG_CAP;
                    else if (HAS_MEM) state_s = MEM_REQ;
                    else              state_s = DONE;
                end else begin
                    state_s = REG_OUT;
                end
            end
            MEM_REQ: state_s = MEM_CAP;
            MEM_CAP: state_s = MEM_OUT;
            MEM_OUT: begin
                if (xfer_s) begin
                    if (mem_last_s) state_s = DONE; else state_s = MEM_REQ;
                end else begin
                    state_s = MEM_OUT;
                end
            end
            DONE:    if (halt_i) state_s = DONE; else state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; the read address for the next word
    // is set up on the transfer edge so it is already valid in the capture/request state
    always_comb begin
        idx_s   = idx_r;
        busy_s  = busy_r;
        done_s  = done_r;
        v_s     = v_r;
        sel_s   = sel_r;
        didx_s  = didx_r;
        data_s  = data_r;
        reg_r_s = reg_r_r;
        mem_a_s = mem_a_r;
        case (state_r)
            IDLE: begin
                done_s = 1'b0;
                if (halt_i) begin
                    idx_s   = {W_IDX{1'b0}};
                    busy_s  = 1'b1;
                    reg_r_s = {W_RD{1'b0}};
                end else begin
                    busy_s  = 1'b0;
                end
            end
            REG_CAP: begin
                data_s = reg_data_i;
                sel_s  = 1'b0;
                didx_s = idx_r;
                v_s    = 1'b1;
            end
            REG_OUT: begin
                if (xfer_s) begin
                    v_s = 1'b0;
                    if (!reg_last_s) begin
                        idx_s   = idx_inc_s;
                        reg_r_s = W_RD'(idx_inc_s);
                    end else if (HAS_MEM) begin
                        idx_s   = {W_IDX{1'b0}};
                        mem_a_s = MEM_BASE;
                    end else begin
                        idx_s   = {W_IDX{1'b0}};
                        busy_s  = 1'b0;
                    end
                end else begin
                    v_s = 1'b1;
                end
            end
            MEM_REQ: mem_a_s = mem_a_r;
            MEM_CAP: begin
                data_s = mem_data_i;
                sel_s  = 1'b1;
                didx_s = idx_r;
                v_s    = 1'b1;
            end
            MEM_OUT: begin
                if (xfer_s) begin
                    v_s = 1'b0;
                    if (mem_last_s) begin
                        busy_s  = 1'b0;
                    end else begin
                        idx_s   = idx_inc_s;
                        mem_a_s = MEM_BASE + ADDR'(idx_inc_s);
                    end
                end else begin
                    v_s = 1'b1;
                end
            end
            DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                v_s    = 1'b0;
            end
        endcase
    end

    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign reg_r_o     = reg_r_r;
    assign mem_a_o     = mem_a_r;
    assign mem_w_o     = 1'b0;
    assign dump_v_o    = v_r;
    assign dump_sel_o  = sel_r;
    assign dump_idx_o  = didx_r;
    assign dump_data_o = data_r;

endmodule

// File: tb/tb_dump_unit.sv
// Directed bench for dump_unit: default config, a register-only config and a
// wrapping memory-window config, all driven from one clock/reset/halt/ready.
module tb_dump_unit;

    typedef struct packed {
        logic        sel;
        logic [7:0]  idx;
        logic [31:0] data;
        logic [31:0] addr;
    } xfer_t;

    int n_chk = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    logic reset, halt, rdy;
    always #5 clk = ~clk;

    logic        busy0, done0, mw0, v0, sel0;
    logic [3:0]  rr0;
    logic [31:0] rd0, ma0, md0, dd0;
    logic [7:0]  idx0;
    logic        busy3, done3, mw3, v3, sel3;
    logic [3:0]  rr3;
    logic [31:0] rd3, ma3, md3, dd3;
    logic [7:0]  idx3;
    logic        busy4, done4, mw4, v4, sel4;
    logic [3:0]  rr4;
    logic [31:0] rd4, ma4, md4, dd4;
    logic [7:0]  idx4;

    dump_unit u0 (
        .clk(clk), .reset(reset), .halt_i(halt), .busy_o(busy0), .done_o(done0),
        .reg_r_o(rr0), .reg_data_i(rd0), .mem_a_o(ma0), .mem_w_o(mw0), .mem_data_i(md0),
        .dump_v_o(v0), .dump_rdy_i(rdy), .dump_sel_o(sel0), .dump_idx_o(idx0), .dump_data_o(dd0)
    );
    dump_unit #(.N_REG(4), .N_MEM(0)) u3 (
        .clk(clk), .reset(reset), .halt_i(halt), .busy_o(busy3), .done_o(done3),
        .reg_r_o(rr3), .reg_data_i(rd3), .mem_a_o(ma3), .mem_w_o(mw3), .mem_data_i(md3),
        .dump_v_o(v3), .dump_rdy_i(rdy), .dump_sel_o(sel3), .dump_idx_o(idx3), .dump_data_o(dd3)
    );
    dump_unit #(.N_REG(2), .N_MEM(4), .MEM_BASE(32'hFFFF_FFFE)) u4 (
        .clk(clk), .reset(reset), .halt_i(halt), .busy_o(busy4), .done_o(done4),
        .reg_r_o(rr4), .reg_data_i(rd4), .mem_a_o(ma4), .mem_w_o(mw4), .mem_data_i(md4),
        .dump_v_o(v4), .dump_rdy_i(rdy), .dump_sel_o(sel4), .dump_idx_o(idx4), .dump_data_o(dd4)
    );

    // Register file r[i] = i * 0x11111111 (nibble replicated)
    assign rd0 = {8{rr0}};
    assign rd3 = {8{rr3}};
    assign rd4 = {8{rr4}};

    // Synchronous-read memories
    always @(posedge clk) begin
        md0 <= 32'h0000_00A0 + ma0;
        md3 <= 32'h0000_00A0 + ma3;
        md4 <= ~ma4;
    end

    xfer_t       q0[$], q3[$], q4[$];
    int          stall_err0 = 0;
    int          ma3_err = 0;
    logic        ps0 = 1'b0;
    logic [40:0] pv0 = 41'd0;

    // Transfer logging and stall-stability tracking
    always @(negedge clk) begin
        if (reset) begin
            if (v0 && rdy) q0.push_back({sel0, idx0, dd0, ma0});
            if (v3 && rdy) q3.push_back({sel3, idx3, dd3, ma3});
            if (v4 && rdy) q4.push_back({sel4, idx4, dd4, ma4});
            if (ps0 && (!v0 || ({sel0, idx0, dd0} !== pv0))) stall_err0 <= stall_err0 + 1;
            ps0 <= v0 && !rdy;
            pv0 <= {sel0, idx0, dd0};
            if (ma3 !== 32'd0) ma3_err <= ma3_err + 1;
        end else begin
            ps0 <= 1'b0;
        end
    end

    function automatic logic [40:0] exp0(input int k);
        logic [31:0] kk;
        if (k < 16) begin
            kk = 32'(k);
            return {1'b0, kk[7:0], kk * 32'h1111_1111};
        end
        kk = 32'(k - 16);
        return {1'b1, kk[7:0], 32'h0000_00A0 + kk};
    endfunction

    task automatic start_dump;
        repeat (100) @(posedge clk);
        q0.delete(); q3.delete(); q4.delete();
        #1 halt = 1'b1;
        @(posedge clk);
        #1 halt = 1'b0;
    endtask

    task automatic wait_done(input int which, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if ((which == 0 && done0) || (which == 3 && done3) || (which == 4 && done4)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; halt = 1'b0; rdy = 1'b1;
        #3;
        n_chk++;
        if ({busy0, done0, v0, sel0, idx0, dd0, rr0, ma0, mw0} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_u0: got %h want 0", {busy0, done0, v0, sel0, idx0, dd0, rr0, ma0, mw0});
        end
        n_chk++;
        if ({busy3, done3, v3, sel3, idx3, dd3, rr3, ma3, mw3, busy4, v4, dd4, ma4} !== 146'd0) begin
            n_fail++;
            $display("FAIL reset_u3u4: outputs not all zero (busy3 %b v3 %b busy4 %b v4 %b ma4 %h)", busy3, v3, busy4, v4, ma4);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_full_dump;
        int n;
        start_dump;
        @(negedge clk);
        n_chk++;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL busy_start: got %b want 1", busy0); end
        wait_done(0, 300, n);
        n_chk++;
        if (n != 81) begin n_fail++; $display("FAIL done_latency: got %0d cycles want 81", n); end
        n_chk++;
        if (q0.size() != 32) begin n_fail++; $display("FAIL full_count: got %0d want 32", q0.size()); end
        for (int i = 0; i < q0.size() && i < 32; i++) begin
            n_chk++;
            if ({q0[i].sel, q0[i].idx, q0[i].data} !== exp0(i)) begin
                n_fail++;
                $display("FAIL full_word%0d: got %h want %h", i, {q0[i].sel, q0[i].idx, q0[i].data}, exp0(i));
            end
        end
        @(negedge clk);
        n_chk++;
        if ({busy0, done0, mw0} !== 3'b000) begin n_fail++; $display("FAIL after_pulse: busy/done/mw got %b want 000", {busy0, done0, mw0}); end
    endtask

    task automatic test_stall;
        int  e0;
        bit  seen;
        e0 = stall_err0;
        start_dump;
        seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(posedge clk);
            #1 rdy = ((k % 3) == 0) || ((k % 7) == 2);
            if (done0) seen = 1'b1;
        end
        rdy = 1'b1;
        @(negedge clk);
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL stall_timeout: done_o got 0 want 1"); end
        n_chk++;
        if (stall_err0 != e0) begin n_fail++; $display("FAIL stall_stable: got %0d changes while stalled want 0", stall_err0 - e0); end
        n_chk++;
        if (q0.size() != 32) begin n_fail++; $display("FAIL stall_count: got %0d want 32", q0.size()); end
        for (int i = 0; i < q0.size() && i < 32; i++) begin
            n_chk++;
            if ({q0[i].sel, q0[i].idx, q0[i].data} !== exp0(i)) begin
                n_fail++;
                $display("FAIL stall_word%0d: got %h want %h", i, {q0[i].sel, q0[i].idx, q0[i].data}, exp0(i));
            end
        end
    endtask

    task automatic test_no_mem;
        int          n, e0;
        logic [31:0] kk;
        e0 = ma3_err;
        start_dump;
        wait_done(3, 100, n);
        n_chk++;
        if (n != 10) begin n_fail++; $display("FAIL nomem_latency: got %0d want 10", n); end
        n_chk++;
        if (q3.size() != 4) begin n_fail++; $display("FAIL nomem_count: got %0d want 4", q3.size()); end
        for (int i = 0; i < q3.size() && i < 4; i++) begin
            kk = 32'(i);
            n_chk++;
            if ({q3[i].sel, q3[i].idx, q3[i].data} !== {1'b0, kk[7:0], kk * 32'h1111_1111}) begin
                n_fail++;
                $display("FAIL nomem_word%0d: got %h want %h", i, {q3[i].sel, q3[i].idx, q3[i].data}, {1'b0, kk[7:0], kk * 32'h1111_1111});
            end
        end
        n_chk++;
        if (ma3_err != e0 || ma3 !== 32'd0) begin n_fail++; $display("FAIL nomem_addr: mem_a_o got %h want 0", ma3); end
    endtask

    task automatic test_wrap;
        int          n;
        logic [31:0] a, kk;
        start_dump;
        wait_done(4, 100, n);
        n_chk++;
        if (n != 18) begin n_fail++; $display("FAIL wrap_latency: got %0d want 18", n); end
        n_chk++;
        if (q4.size() != 6) begin n_fail++; $display("FAIL wrap_count: got %0d want 6", q4.size()); end
        for (int i = 2; i < q4.size() && i < 6; i++) begin
            kk = 32'(i - 2);
            a  = 32'hFFFF_FFFE + kk;
            n_chk++;
            if (q4[i] !== {1'b1, kk[7:0], ~a, a}) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got %h want %h", i, q4[i], {1'b1, kk[7:0], ~a, a});
            end
        end
        n_chk++;
        if (q4.size() > 1 && {q4[1].sel, q4[1].idx, q4[1].data} !== 41'h0_01_1111_1111) begin
            n_fail++;
            $display("FAIL wrap_reg1: got %h want 00111111111", {q4[1].sel, q4[1].idx, q4[1].data});
        end
    endtask

    task automatic test_halt_hold;
        int n;
        repeat (100) @(posedge clk);
        q0.delete();
        #1 halt = 1'b1;
        wait_done(0, 300, n);
        repeat (40) @(negedge clk);
        n_chk++;
        if ({done0, busy0} !== 2'b10 || q0.size() != 32) begin
            n_fail++;
            $display("FAIL hold_no_retrigger: done %b busy %b words %0d want done 1 busy 0 words 32", done0, busy0, q0.size());
        end
        @(posedge clk);
        #1 halt = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({done0, busy0} !== 2'b00) begin n_fail++; $display("FAIL hold_release: done/busy got %b want 00", {done0, busy0}); end
        start_dump;
        wait_done(0, 300, n);
        n_chk++;
        if (q0.size() != 32) begin n_fail++; $display("FAIL redump_count: got %0d want 32", q0.size()); end
        for (int i = 0; i < q0.size() && i < 32; i++) begin
            n_chk++;
            if ({q0[i].sel, q0[i].idx, q0[i].data} !== exp0(i)) begin
                n_fail++;
                $display("FAIL redump_word%0d: got %h want %h", i, {q0[i].sel, q0[i].idx, q0[i].data}, exp0(i));
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit found;
        start_dump;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (v0 && sel0 && idx0 == 8'd3) begin found = 1'b1; break; end
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if (!found || {busy0, done0, v0, sel0, idx0, dd0, rr0, ma0, mw0} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_mid: found %b v %b sel %b idx %h data %h ma %h want all 0", found, v0, sel0, idx0, dd0, ma0);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        halt = 1'b0;
        q0.delete();
        repeat (20) @(negedge clk);
        n_chk++;
        if (q0.size() != 0 || {busy0, v0} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_quiet: words %0d busy %b v %b want 0 0 0", q0.size(), busy0, v0);
        end
        start_dump;
        wait_done(0, 300, n);
        n_chk++;
        if (q0.size() != 32) begin n_fail++; $display("FAIL restart_count: got %0d want 32", q0.size()); end
        n_chk++;
        if ({q0[0].sel, q0[0].idx, q0[0].data} !== exp0(0) || {q0[31].sel, q0[31].idx, q0[31].data} !== exp0(31)) begin
            n_fail++;
            $display("FAIL restart_order: first %h last %h want %h %h", {q0[0].sel, q0[0].idx, q0[0].data}, {q0[31].sel, q0[31].idx, q0[31].data}, exp0(0), exp0(31));
        end
    endtask

    initial begin
        test_reset;
        test_full_dump;
        test_stall;
        test_no_mem;
        test_wrap;
        test_halt_hold;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
